// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory subsystem.
//   word_t      : 32-bit machine word
//   ramstate_t  : RAM handshake status reported back to the arbiter
//   arb_state_t : memory arbiter grant state
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DATA  = 2'd1,
        ARB_INSTR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single RAM port between instruction fetch and
// data access. Data normally wins; after STARVE_MAX data completions with a
// fetch pending, the fetch is forced. A grant lasts one whole RAM transaction
// and every transaction is separated by one ARB_IDLE cycle.
//
// Ports
//   CLK, nRST                  clock, synchronous active-low reset
//   iREN, iaddr                instruction read request / address
//   iwait, iload               fetch wait (low on completion) / fetch data
//   dREN, dWEN, daddr, dstore  data read/write request, address, write value
//   dwait, dload               data wait (low on completion) / read data
//   ramREN, ramWEN, ramaddr,   RAM request side, driven combinationally
//   ramstore                   from the granted requester
//   ramload, ramstate          RAM read data and handshake status
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter  int unsigned STARVE_MAX = 4,
    localparam int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Read data is passed straight through; the wait strobes qualify it.
    assign iload = ramload;
    assign dload = ramload;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = 1'b1;
        dwait        = 1'b1;

        unique case (state_q)
            ARB_IDLE: begin
                if (iREN && (starve_cnt_q == CNT_MAX)) begin
                    state_d = ARB_INSTR;
                end else if (dREN || dWEN) begin
                    state_d = ARB_DATA;
                end else if (iREN) begin
                    state_d = ARB_INSTR;
                end
            end

            ARB_DATA: begin
                if (!(dREN || dWEN)) begin
                    // Requester withdrew: release the port without completing.
                    state_d = ARB_IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == ACCESS) begin
                        dwait   = 1'b0;
                        state_d = ARB_IDLE;
                        if (!iREN) begin
                            starve_cnt_d = '0;
                        end else if (starve_cnt_q != CNT_MAX) begin
                            starve_cnt_d = starve_cnt_q + CNT_W'(1);
                        end
                    end else if (ramstate == ERROR) begin
                        // Drop back to IDLE so the retry is re-arbitrated.
                        state_d = ARB_IDLE;
                    end
                end
            end

            ARB_INSTR: begin
                if (!iREN) begin
                    state_d = ARB_IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ramstate == ACCESS) begin
                        iwait        = 1'b0;
                        starve_cnt_d = '0;
                        state_d      = ARB_IDLE;
                    end else if (ramstate == ERROR) begin
                        state_d = ARB_IDLE;
                    end
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

endmodule
